// File: rtl/ga20_fetch_arb.sv
// ga20_fetch_arb: round-robin scheduler that lets the GA20 playback channels
// share the single sample-cache read port. One byte fetch is outstanding at a
// time. Each fetched byte goes back to its channel with a one-cycle
// acknowledge. A watchdog forces completion if the cache never answers.

module ga20_fetch_arb #(
    parameter int NCH     = 4,
    parameter int AW      = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              pause,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH-1:0]    ch_ack,
    output logic [7:0]        ch_dout,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_din,
    output logic              busy,
    output logic              err
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    // Watchdog value seen on the cycle before the forced completion edge.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   last_r;
    logic [7:0]      wdog_r;

    logic            any_req_s;
    logic [GW-1:0]   pick_s;
    logic [AW-1:0]   pick_addr_s;
    logic [NCH-1:0]  ack_vec_s;

    // Round-robin choice. Channels above the last grant win first. If none of
    // them is requesting, the scan wraps to channels at or below it.
    function automatic logic [GW-1:0] rr_pick(input logic [NCH-1:0] req,
                                              input logic [GW-1:0]  last);
        logic [GW-1:0] pick;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!found && req[c] && (c > int'(last))) begin
                pick  = GW'(c);
                found = 1'b1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!found && req[c] && (c <= int'(last))) begin
                pick  = GW'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next-grant selection, its address, and the ack decode of the current grant.
    always_comb begin
        any_req_s   = |ch_req;
        pick_s      = rr_pick(ch_req, last_r);
        pick_addr_s = {AW{1'b0}};
        ack_vec_s   = {NCH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (GW'(c) == pick_s) begin
                pick_addr_s = ch_addr[c*AW +: AW];
            end else begin
                pick_addr_s = pick_addr_s;
            end
            ack_vec_s[c] = (GW'(c) == grant_r);
        end
    end

    // Fetch FSM. Every output is registered here so it changes only on clk_sys.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= {GW{1'b0}};
            last_r   <= GW'(NCH - 1);
            wdog_r   <= 8'd0;
            mem_rd   <= 1'b0;
            mem_addr <= {AW{1'b0}};
            ch_ack   <= {NCH{1'b0}};
            ch_dout  <= 8'h00;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ch_ack <= {NCH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!pause && any_req_s) begin
                        mem_addr <= pick_addr_s;
                        mem_rd   <= 1'b1;
                        grant_r  <= pick_s;
                        wdog_r   <= 8'd0;
                        busy     <= 1'b1;
                        state_r  <= ST_BUSY;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_valid) begin
                        // Real data wins even on the watchdog's final cycle.
                        ch_dout <= mem_din;
                        ch_ack  <= ack_vec_s;
                        mem_rd  <= 1'b0;
                        busy    <= 1'b0;
                        last_r  <= grant_r;
                        state_r <= ST_IDLE;
                    end else if (wdog_r == WD_LAST) begin
                        // Stalled cache: release the requester with a zero
                        // byte and remember the fault. Fairness still advances.
                        ch_dout <= 8'h00;
                        ch_ack  <= ack_vec_s;
                        mem_rd  <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        last_r  <= grant_r;
                        state_r <= ST_IDLE;
                    end else begin
                        wdog_r  <= wdog_r + 8'd1;
                    end
                end
                default: begin
                    mem_rd  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    ga20_fetch_arb_chk #(
        .NCH (NCH),
        .AW  (AW)
    ) u_chk (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ch_ack   (ch_ack),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .mem_addr (mem_addr)
    );

endmodule

// ga20_fetch_arb_chk: protocol properties of the scheduler outputs.
module ga20_fetch_arb_chk #(
    parameter int NCH = 4,
    parameter int AW  = 20
) (
    input logic            clk_sys,
    input logic            reset_n,
    input logic [NCH-1:0]  ch_ack,
    input logic            mem_rd,
    input logic            busy,
    input logic [AW-1:0]   mem_addr
);

    // At most one channel is acknowledged at a time.
    ack_onehot: assert property (@(posedge clk_sys) disable iff (!reset_n)
        $onehot0(ch_ack));

    // An acknowledge lasts exactly one cycle.
    ack_single: assert property (@(posedge clk_sys) disable iff (!reset_n)
        (|ch_ack) |=> !(|ch_ack));

    // The cache read request follows the busy state.
    rd_busy: assert property (@(posedge clk_sys) disable iff (!reset_n)
        mem_rd == busy);

    // The cache address stays fixed while a read is outstanding.
    addr_hold: assert property (@(posedge clk_sys) disable iff (!reset_n)
        (mem_rd && $past(mem_rd)) |-> $stable(mem_addr));

endmodule

// File: tb/tb_ga20_fetch_arb.sv
// Self-checking bench for ga20_fetch_arb: directed vector table, hand-written
// timeout/reset sequences, and random traffic against a transaction model.
module tb_ga20_fetch_arb;

    localparam int NCH     = 4;
    localparam int AW      = 20;
    localparam int TIMEOUT = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              pause;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_ack;
    logic [7:0]        ch_dout;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic              mem_valid;
    logic [7:0]        mem_din;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;

    ga20_fetch_arb #(.NCH(NCH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .pause     (pause),
        .ch_req    (ch_req),
        .ch_addr   (ch_addr),
        .ch_ack    (ch_ack),
        .ch_dout   (ch_dout),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_din   (mem_din),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          rst;
        logic        ps;
        logic [3:0]  req;
        logic [79:0] ad;
        logic        vld;
        logic [7:0]  din;
        logic [3:0]  e_ack;
        logic        e_rd;
        logic [19:0] e_addr;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic ps, logic [3:0] req, logic [79:0] ad,
                                logic vld, logic [7:0] din, logic [3:0] e_ack,
                                logic e_rd, logic [19:0] e_addr, logic [7:0] e_dout);
        vec_t v;
        v.rst = rst; v.ps = ps; v.req = req; v.ad = ad; v.vld = vld; v.din = din;
        v.e_ack = e_ack; v.e_rd = e_rd; v.e_addr = e_addr; v.e_dout = e_dout;
        return v;
    endfunction

    function automatic logic [79:0] a4(logic [19:0] a0, logic [19:0] a1,
                                       logic [19:0] a2, logic [19:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input bit check);
        reset_n   = 1'b0;
        pause     = 1'b0;
        ch_req    = 4'b0000;
        ch_addr   = 80'd0;
        mem_valid = 1'b0;
        mem_din   = 8'h00;
        repeat (2) tick();
        if (check) begin
            chk("rst_rd",   32'(mem_rd),   32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_ack",  32'(ch_ack),   32'd0);
            chk("rst_dout", 32'(ch_dout),  32'd0);
            chk("rst_busy", 32'(busy),     32'd0);
            chk("rst_err",  32'(err),      32'd0);
        end
        reset_n = 1'b1;
    endtask

    // Reference model state: one transaction at a time, fairness pointer.
    int         m_last;
    int         m_grant;
    int         m_wait;
    bit         m_busy;
    bit         m_err;
    logic [19:0] m_addr;
    logic [7:0]  m_dout;
    logic [3:0]  e_ack;

    task automatic model_step();
        e_ack = 4'b0000;
        if (!m_busy) begin
            if (!pause && (ch_req != 4'b0000)) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (ch_req[(m_last + k) % NCH]) begin
                        m_grant = (m_last + k) % NCH;
                        break;
                    end
                end
                for (int c = 0; c < NCH; c++)
                    if (c == m_grant) m_addr = ch_addr[c*AW +: AW];
                m_busy = 1'b1;
                m_wait = 0;
            end
        end else if (mem_valid) begin
            for (int c = 0; c < NCH; c++) if (c == m_grant) e_ack[c] = 1'b1;
            m_dout = mem_din;
            m_busy = 1'b0;
            m_last = m_grant;
        end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                for (int c = 0; c < NCH; c++) if (c == m_grant) e_ack[c] = 1'b1;
                m_dout = 8'h00;
                m_err  = 1'b1;
                m_busy = 1'b0;
                m_last = m_grant;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 ns");
        $fatal(1, "time limit");
    end

    initial begin
        logic [79:0] aa;
        logic [79:0] af;
        logic [79:0] ap;

        // Single request, three wait cycles.
        aa = a4(20'h12345, 20'h0, 20'h0, 20'h0);
        tbl.push_back(mk(1, 0, 4'b0001, aa, 0, 8'h00, 4'b0000, 1, 20'h12345, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0001, aa, 0, 8'h00, 4'b0000, 1, 20'h12345, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0001, aa, 0, 8'h00, 4'b0000, 1, 20'h12345, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0001, aa, 1, 8'hA5, 4'b0001, 0, 20'h0,     8'hA5));
        tbl.push_back(mk(0, 0, 4'b0000, aa, 0, 8'h00, 4'b0000, 0, 20'h0,     8'h00));
        // All four at once, zero-wait cache: grants 0,1,2,3 two cycles apart.
        aa = a4(20'h00100, 20'h00200, 20'h00300, 20'h00400);
        tbl.push_back(mk(1, 0, 4'b1111, aa, 1, 8'h10, 4'b0000, 1, 20'h00100, 8'h00));
        tbl.push_back(mk(0, 0, 4'b1111, aa, 1, 8'h11, 4'b0001, 0, 20'h0,     8'h11));
        tbl.push_back(mk(0, 0, 4'b1110, aa, 1, 8'h12, 4'b0000, 1, 20'h00200, 8'h00));
        tbl.push_back(mk(0, 0, 4'b1110, aa, 1, 8'h13, 4'b0010, 0, 20'h0,     8'h13));
        tbl.push_back(mk(0, 0, 4'b1100, aa, 1, 8'h14, 4'b0000, 1, 20'h00300, 8'h00));
        tbl.push_back(mk(0, 0, 4'b1100, aa, 1, 8'h15, 4'b0100, 0, 20'h0,     8'h15));
        tbl.push_back(mk(0, 0, 4'b1000, aa, 1, 8'h16, 4'b0000, 1, 20'h00400, 8'h00));
        tbl.push_back(mk(0, 0, 4'b1000, aa, 1, 8'h17, 4'b1000, 0, 20'h0,     8'h17));
        tbl.push_back(mk(0, 0, 4'b0000, aa, 1, 8'h18, 4'b0000, 0, 20'h0,     8'h00));
        // Fairness: after channel 2, channels 1 and 3 together -> 3 then 1.
        af = a4(20'h0, 20'h11111, 20'hABCDE, 20'h33333);
        tbl.push_back(mk(1, 0, 4'b0100, af, 0, 8'h00, 4'b0000, 1, 20'hABCDE, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0100, af, 1, 8'h5A, 4'b0100, 0, 20'h0,     8'h5A));
        tbl.push_back(mk(0, 0, 4'b1010, af, 0, 8'h00, 4'b0000, 1, 20'h33333, 8'h00));
        tbl.push_back(mk(0, 0, 4'b1010, af, 1, 8'h33, 4'b1000, 0, 20'h0,     8'h33));
        tbl.push_back(mk(0, 0, 4'b0010, af, 0, 8'h00, 4'b0000, 1, 20'h11111, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0010, af, 1, 8'h11, 4'b0010, 0, 20'h0,     8'h11));
        tbl.push_back(mk(0, 0, 4'b0000, af, 0, 8'h00, 4'b0000, 0, 20'h0,     8'h00));
        // Pause during channel 1's fetch with channel 2 pending.
        ap = a4(20'h0, 20'h00A01, 20'h00A02, 20'h0);
        tbl.push_back(mk(1, 0, 4'b0110, ap, 0, 8'h00, 4'b0000, 1, 20'h00A01, 8'h00));
        tbl.push_back(mk(0, 1, 4'b0110, ap, 0, 8'h00, 4'b0000, 1, 20'h00A01, 8'h00));
        tbl.push_back(mk(0, 1, 4'b0110, ap, 1, 8'h77, 4'b0010, 0, 20'h0,     8'h77));
        tbl.push_back(mk(0, 1, 4'b0100, ap, 1, 8'h00, 4'b0000, 0, 20'h0,     8'h00));
        tbl.push_back(mk(0, 1, 4'b0100, ap, 0, 8'h00, 4'b0000, 0, 20'h0,     8'h00));
        tbl.push_back(mk(0, 0, 4'b0100, ap, 0, 8'h00, 4'b0000, 1, 20'h00A02, 8'h00));
        tbl.push_back(mk(0, 0, 4'b0100, ap, 1, 8'h88, 4'b0100, 0, 20'h0,     8'h88));
        tbl.push_back(mk(0, 0, 4'b0000, ap, 0, 8'h00, 4'b0000, 0, 20'h0,     8'h00));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(1'b1);
            pause     = tbl[i].ps;
            ch_req    = tbl[i].req;
            ch_addr   = tbl[i].ad;
            mem_valid = tbl[i].vld;
            mem_din   = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d_ack", i),  32'(ch_ack), 32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_rd", i),   32'(mem_rd), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_busy", i), 32'(busy),   32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_err", i),  32'(err),    32'd0);
            if (tbl[i].e_rd)
                chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_ack != 4'b0000)
                chk($sformatf("tbl%0d_dout", i), 32'(ch_dout), 32'(tbl[i].e_dout));
        end

        // Watchdog expiry: ack with 00 exactly TIMEOUT cycles after entering BUSY.
        do_reset(1'b0);
        ch_req  = 4'b0001;
        ch_addr = a4(20'h00777, 20'h00888, 20'h0, 20'h0);
        tick();
        chk("to_enter_rd", 32'(mem_rd), 32'd1);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk($sformatf("to_wait%0d_ack", k), 32'(ch_ack), 32'd0);
            chk($sformatf("to_wait%0d_busy", k), 32'(busy), 32'd1);
        end
        tick();
        chk("to_ack",  32'(ch_ack),  32'b0001);
        chk("to_dout", 32'(ch_dout), 32'h00);
        chk("to_err",  32'(err),     32'd1);
        chk("to_rd",   32'(mem_rd),  32'd0);
        ch_req = 4'b0010;
        tick();
        chk("to_next_addr", 32'(mem_addr), 32'h00888);
        mem_valid = 1'b1;
        mem_din   = 8'h3C;
        tick();
        chk("to_next_ack",  32'(ch_ack),  32'b0010);
        chk("to_next_dout", 32'(ch_dout), 32'h3C);
        chk("to_next_err",  32'(err),     32'd1);
        mem_valid = 1'b0;
        ch_req    = 4'b0000;
        tick();

        // mem_valid on the expiry edge counts as a normal completion.
        do_reset(1'b0);
        ch_req  = 4'b0001;
        ch_addr = a4(20'h00999, 20'h0, 20'h0, 20'h0);
        tick();
        for (int k = 1; k < TIMEOUT; k++) tick();
        mem_valid = 1'b1;
        mem_din   = 8'hC3;
        tick();
        chk("edge_ack",  32'(ch_ack),  32'b0001);
        chk("edge_dout", 32'(ch_dout), 32'hC3);
        chk("edge_err",  32'(err),     32'd0);
        mem_valid = 1'b0;
        ch_req    = 4'b0000;

        // Asynchronous reset mid-fetch, then the first grant goes to channel 0.
        do_reset(1'b0);
        ch_req  = 4'b0100;
        ch_addr = a4(20'h00055, 20'h0, 20'h00ABC, 20'h0);
        tick();
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_rd",   32'(mem_rd), 32'd0);
        chk("ar_ack",  32'(ch_ack), 32'd0);
        chk("ar_busy", 32'(busy),   32'd0);
        ch_req = 4'b0101;
        tick();
        chk("ar_hold_ack", 32'(ch_ack), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("ar_first_rd",   32'(mem_rd),   32'd1);
        chk("ar_first_addr", 32'(mem_addr), 32'h00055);
        ch_req = 4'b0000;

        // Random traffic against the transaction model.
        do_reset(1'b0);
        m_last = NCH - 1;
        m_grant = 0;
        m_wait = 0;
        m_busy = 1'b0;
        m_err = 1'b0;
        m_addr = 20'h0;
        m_dout = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!ch_req[c] && ($urandom_range(0, 3) == 0)) begin
                    ch_req[c] = 1'b1;
                    ch_addr[c*AW +: AW] = AW'($urandom);
                end else if (ch_req[c] && ($urandom_range(0, 63) == 0)) begin
                    ch_req[c] = 1'b0;
                end
            end
            pause     = ($urandom_range(0, 7) == 0);
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_din   = 8'($urandom);
            @(posedge clk_sys);
            model_step();
            #1;
            chk("rnd_ack",  32'(ch_ack), 32'(e_ack));
            chk("rnd_rd",   32'(mem_rd), 32'(m_busy));
            chk("rnd_busy", 32'(busy),   32'(m_busy));
            chk("rnd_err",  32'(err),    32'(m_err));
            if (m_busy) chk("rnd_addr", 32'(mem_addr), 32'(m_addr));
            if (e_ack != 4'b0000) chk("rnd_dout", 32'(ch_dout), 32'(m_dout));
            for (int c = 0; c < NCH; c++)
                if (e_ack[c] && ($urandom_range(0, 1) == 0)) ch_req[c] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ga20_fetch_arb.md
# ga20_fetch_arb

Round-robin fetch scheduler that shares the single GA20 sample-cache read port among the GA20's four playback channels. It sits between the per-channel sample address generators and the sample cache. It serialises their byte fetches, returns each byte with a one-cycle acknowledge, and guards against a stalled memory path with a watchdog. Runs entirely in the 40 MHz system domain.

## Interface
- `NCH`, 4, number of requesting channels (2..8)
- `AW`, 20, sample address width
- `TIMEOUT`, 255, cycles in BUSY without `mem_valid` before forced completion (1..255)

Ports:
- `clk_sys`  in  1  system clock, 40 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `pause`  in  1  when high, no new grants are issued; an in-flight fetch still completes
- `ch_req`  in  NCH  per-channel fetch request, level-held until `ch_ack`
- `ch_addr`  in  NCH*AW  per-channel byte address, channel i at bits [i*AW +: AW], stable while `ch_req[i]` is high
- `ch_ack`  out  NCH  one-cycle pulse: `ch_dout` is valid for channel i
- `ch_dout`  out  8  fetched byte, shared by all channels, qualified by `ch_ack`
- `mem_rd`  out  1  read request to cache, level-held until `mem_valid`
- `mem_addr`  out  AW  cache read address, stable while `mem_rd` is high
- `mem_valid`  in  1  cache data valid for the current `mem_addr`
- `mem_din`  in  8  cache data
- `busy`  out  1  high in BUSY state
- `err`  out  1  sticky flag: a watchdog timeout has occurred

## Operation
- State machine has two states: IDLE and BUSY. Reset state is IDLE.
- Reset values: `mem_rd`=0, `mem_addr`=0, `ch_ack`=0, `ch_dout`=0, `busy`=0, `err`=0, last-grant pointer=NCH-1 (so channel 0 wins first), watchdog=0.
- IDLE behaviour, when `pause`=0 and any `ch_req` bit is set:
  - Select the first set bit scanning from last-grant+1 upward, wrapping modulo NCH.
  - Latch that channel's address into `mem_addr`, set `mem_rd`=1, record the grant index, clear the watchdog, go to BUSY.
- BUSY behaviour on `mem_valid`=1:
  - `ch_dout` ← `mem_din`.
  - `ch_ack[grant]` ← 1 for one cycle.
  - `mem_rd` ← 0, last-grant ← grant, go to IDLE.
- BUSY behaviour, otherwise: the watchdog increments. When it reaches TIMEOUT:
  - Complete as for `mem_valid`, but with `ch_dout`=8'h00.
  - Set `err`=1.
- Ack is issued to the granted channel even if its `ch_req` dropped mid-fetch; the requester discards it.
- Changes to `ch_addr` of the granted channel during BUSY are ignored, because `mem_addr` is latched.
- `pause` affects IDLE only. Requests stay pending while paused.
- Last-grant updates only on completion, so a timeout still advances fairness.
- `err` clears only on reset.

## Timing
- `ch_req` first sampled high in IDLE at edge T → `mem_rd`=1 and `mem_addr` valid after edge T.
- `mem_valid` sampled high at edge V → `ch_ack` and `ch_dout` valid after edge V, and `mem_rd`=0 after edge V.
- The next grant is decided at edge V+1, so `mem_rd` rises again after edge V+1. Minimum fetch period is 2 cycles.
- `mem_valid` is ignored in IDLE.
- Timeout: the watchdog counts BUSY cycles without `mem_valid`. The forced completion happens at the edge where the count reaches TIMEOUT, i.e. TIMEOUT cycles after entering BUSY.
- If `mem_valid` arrives on the same edge the watchdog would expire, it counts as normal completion: real data is returned and `err` is unchanged.
- `ch_ack` is never high for more than one cycle and never for more than one channel at a time.
- Asynchronous reset mid-fetch:
  - All outputs return immediately to their reset values.
  - No ack is issued and the in-flight fetch is abandoned.
  - The cache must tolerate `mem_rd` dropping.

## Test plan
- Single request: `ch_req`=0001, `ch_addr[0]`=20'h12345, cache returns 8'hA5 three cycles later. Expect `mem_addr`=12345 and one `ch_ack`=0001 pulse with `ch_dout`=A5.
- All four channels request at once with addresses 0x100/0x200/0x300/0x400. Expect grant order 0,1,2,3, and `mem_addr` sequence 100,200,300,400. With zero-wait `mem_valid`, gaps of exactly 2 cycles.
- Fairness: after channel 2 is served, channels 1 and 3 request together. Expect 3 first, then 1.
- Timeout with TIMEOUT=8 and `mem_valid` held low. Expect `ch_ack` after 8 BUSY cycles with `ch_dout`=00 and `err`=1. A following request with valid data completes normally and `err` stays 1.
- Pause: assert `pause` while channel 1's fetch is in flight, with channel 2 pending. Expect channel 1 to ack, then no `mem_rd` until `pause` drops, then channel 2 is served.
- Reset: assert `reset_n`=0 during BUSY. Expect `mem_rd`=0, `ch_ack`=0 and `busy`=0 immediately. After release, the first grant goes to channel 0.
